// File: rtl/aib_link_ctrl_pkg.sv
// Shared definitions for the AIB link controller: state encodings,
// default training/idle words and a width helper for the counters.
package aib_link_ctrl_pkg;

    localparam int          DEF_DATA_WIDTH    = 80;
    localparam logic [79:0] DEF_TRAIN_PATTERN = {10{8'hA5}};
    localparam logic [79:0] DEF_IDLE_WORD     = 80'h0;
    localparam int          DEF_TRAIN_COUNT   = 16;
    localparam int          DEF_CAL_TIMEOUT   = 1023;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAL    = 3'd1,
        ST_TRAIN  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FAIL   = 3'd4
    } link_state_t;

    // Bits needed to hold values 0..value-1; never returns zero so a
    // degenerate parameter still yields a legal vector width.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/aib_train_checker.sv
// Training-pattern detector: counts consecutive cycles on which the
// received word equals the training pattern and flags alignment.
module aib_train_checker
    import aib_link_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                    TRAIN_COUNT   = DEF_TRAIN_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] rx_word,
    output logic                  aligned
);

    localparam int               CNT_W    = clog2(TRAIN_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TRAIN_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_COUNT - 1);

    logic [CNT_W-1:0] match_cnt;
    logic             match;

    assign match = (rx_word == TRAIN_PATTERN);

    // Aligned means the count reaches TRAIN_COUNT at the coming edge, so the
    // FSM can leave TRAIN right after the last required matching word.
    assign aligned = (match_cnt == CNT_MAX) || (match && (match_cnt == CNT_LAST));

    // Consecutive-match counter: any mismatch restarts it, and it sticks at TRAIN_COUNT.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            match_cnt <= '0;
        end else if (!match) begin
            match_cnt <= '0;
        end else if (match_cnt != CNT_MAX) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aib_link_ctrl.sv
// Link bring-up sequencer and data gate for one AIB channel:
// IDLE -> CAL (PHY calibration) -> TRAIN (pattern alignment) -> ACTIVE,
// with a sticky FAIL on calibration or training timeout.
module aib_link_ctrl
    import aib_link_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                    TRAIN_COUNT   = DEF_TRAIN_COUNT,
    parameter int                    CAL_TIMEOUT   = DEF_CAL_TIMEOUT,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DEF_IDLE_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  link_en,
    output logic                  cal_req,
    input  logic                  cal_done,
    output logic [DATA_WIDTH-1:0] aib_tx_data,
    input  logic [DATA_WIDTH-1:0] aib_rx_data,
    input  logic [DATA_WIDTH-1:0] usr_tx_data,
    input  logic                  usr_tx_valid,
    output logic                  usr_tx_ready,
    output logic [DATA_WIDTH-1:0] usr_rx_data,
    output logic                  usr_rx_valid,
    output logic                  link_up,
    output logic                  link_err,
    output logic [2:0]            state_o
);

    localparam int                 TIMER_W   = clog2(CAL_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CAL_TIMEOUT);

    link_state_t           state_q;
    link_state_t           next_state;
    logic [TIMER_W-1:0]    timer_q;
    logic                  aligned;
    logic                  checker_clear;
    logic                  stay_active;
    logic                  cal_req_d;
    logic                  link_up_d;
    logic                  link_err_d;
    logic                  tx_ready_d;
    logic                  rx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic [DATA_WIDTH-1:0] rx_data_d;

    // The match counter only runs while training; outside TRAIN it is held at zero.
    assign checker_clear = (state_q != ST_TRAIN);
    assign state_o       = state_q;

    aib_train_checker #(
        .DATA_WIDTH    (DATA_WIDTH),
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .TRAIN_COUNT   (TRAIN_COUNT)
    ) u_train_checker (
        .clk     (clk),
        .rst     (rst),
        .clear   (checker_clear),
        .rx_word (aib_rx_data),
        .aligned (aligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state rules; dropping link_en overrides everything, and progress beats timeout on a tie.
    always_comb begin
        next_state = state_q;
        if (!link_en) begin
            next_state = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   next_state = ST_CAL;
                ST_CAL: begin
                    if (cal_done) begin
                        next_state = ST_TRAIN;
                    end else if (timer_q == TIMER_MAX) begin
                        next_state = ST_FAIL;
                    end
                end
                ST_TRAIN: begin
                    if (aligned) begin
                        next_state = ST_ACTIVE;
                    end else if (timer_q == TIMER_MAX) begin
                        next_state = ST_FAIL;
                    end
                end
                ST_ACTIVE: next_state = ST_ACTIVE;
                ST_FAIL:   next_state = ST_FAIL;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Per-state cycle timer: restarts from zero on every state change and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (next_state != state_q) begin
            timer_q <= '0;
        end else if (((state_q == ST_CAL) || (state_q == ST_TRAIN)) && (timer_q != TIMER_MAX)) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Output values for the next cycle, decoded from the state being entered.
    always_comb begin
        cal_req_d   = (next_state == ST_CAL);
        link_up_d   = (next_state == ST_ACTIVE);
        link_err_d  = (next_state == ST_FAIL);
        tx_ready_d  = (next_state == ST_ACTIVE);
        stay_active = (state_q == ST_ACTIVE) && (next_state == ST_ACTIVE);
        tx_data_d   = IDLE_WORD;
        if (next_state == ST_TRAIN) begin
            tx_data_d = TRAIN_PATTERN;
        end else if (stay_active && usr_tx_valid) begin
            tx_data_d = usr_tx_data;
        end
        rx_data_d  = stay_active ? aib_rx_data : usr_rx_data;
        rx_valid_d = stay_active && (aib_rx_data != IDLE_WORD) && (aib_rx_data != TRAIN_PATTERN);
    end

    // Output registers; usr_rx_data keeps its last payload except on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cal_req      <= 1'b0;
            link_up      <= 1'b0;
            link_err     <= 1'b0;
            usr_tx_ready <= 1'b0;
            usr_rx_valid <= 1'b0;
            aib_tx_data  <= IDLE_WORD;
            usr_rx_data  <= '0;
        end else begin
            cal_req      <= cal_req_d;
            link_up      <= link_up_d;
            link_err     <= link_err_d;
            usr_tx_ready <= tx_ready_d;
            usr_rx_valid <= rx_valid_d;
            aib_tx_data  <= tx_data_d;
            usr_rx_data  <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_aib_link_ctrl.sv
// Directed-plus-random bench for aib_link_ctrl. A cycle-level reference
// model (plain integers: state number, cycles spent in the state, length of
// the current run of pattern words) predicts every output after each edge;
// loopback traffic is also tracked word-by-word in a queue.
module tb_aib_link_ctrl;

    localparam int          TRAIN_COUNT = 16;
    localparam int          CAL_TIMEOUT = 1023;
    localparam logic [79:0] PAT         = {10{8'hA5}};
    localparam logic [79:0] IDLE_W      = 80'h0;
    localparam int          S_IDLE = 0, S_CAL = 1, S_TRAIN = 2, S_ACTIVE = 3, S_FAIL = 4;

    logic        clk;
    logic        rst;
    logic        link_en;
    logic        cal_req;
    logic        cal_done;
    logic [79:0] aib_tx_data;
    logic [79:0] aib_rx_data;
    logic [79:0] usr_tx_data;
    logic        usr_tx_valid;
    logic        usr_tx_ready;
    logic [79:0] usr_rx_data;
    logic        usr_rx_valid;
    logic        link_up;
    logic        link_err;
    logic [2:0]  state_o;

    logic        loopback;
    logic [79:0] rx_force;

    int          vectors     = 0;
    int          miscompares = 0;
    int          rx_pulses   = 0;

    // Reference model state
    int          m_state;
    int          m_cyc;
    int          m_run;
    logic [79:0] m_tx;
    logic [79:0] m_rxd;
    logic        m_rxv;
    logic [79:0] sb[$];

    assign aib_rx_data = loopback ? aib_tx_data : rx_force;

    aib_link_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .link_en      (link_en),
        .cal_req      (cal_req),
        .cal_done     (cal_done),
        .aib_tx_data  (aib_tx_data),
        .aib_rx_data  (aib_rx_data),
        .usr_tx_data  (usr_tx_data),
        .usr_tx_valid (usr_tx_valid),
        .usr_tx_ready (usr_tx_ready),
        .usr_rx_data  (usr_rx_data),
        .usr_rx_valid (usr_rx_valid),
        .link_up      (link_up),
        .link_err     (link_err),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] randWord();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    // Pattern ends in an odd nibble, so a word with bit 0 clear never matches it.
    function automatic logic [79:0] nonPatternWord();
        logic [79:0] w;
        w    = randWord();
        w[0] = 1'b0;
        return w;
    endfunction

    task automatic checkSignal(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs the DUT sampled.
    task automatic modelStep();
        logic [79:0] r;
        int          ns;
        r = loopback ? m_tx : rx_force;
        if (rst) begin
            m_state = S_IDLE; m_cyc = 0; m_run = 0;
            m_tx = IDLE_W; m_rxd = '0; m_rxv = 1'b0;
        end else if (!link_en) begin
            m_state = S_IDLE; m_cyc = 0; m_run = 0;
            m_tx = IDLE_W; m_rxv = 1'b0;
        end else begin
            ns = m_state;
            if (m_state == S_IDLE) begin
                ns = S_CAL;
            end else if (m_state == S_CAL) begin
                if (cal_done) ns = S_TRAIN;
                else if (m_cyc == CAL_TIMEOUT) ns = S_FAIL;
            end else if (m_state == S_TRAIN) begin
                m_run = (r == PAT) ? ((m_run < TRAIN_COUNT) ? m_run + 1 : m_run) : 0;
                if (m_run == TRAIN_COUNT) ns = S_ACTIVE;
                else if (m_cyc == CAL_TIMEOUT) ns = S_FAIL;
            end
            if (ns == S_TRAIN) m_tx = PAT;
            else if (m_state == S_ACTIVE && usr_tx_valid) m_tx = usr_tx_data;
            else m_tx = IDLE_W;
            if (m_state == S_ACTIVE) begin
                m_rxd = r;
                m_rxv = (r != IDLE_W) && (r != PAT);
            end else begin
                m_rxv = 1'b0;
            end
            m_cyc = (ns == m_state) ? m_cyc + 1 : 0;
            if (ns != S_TRAIN) m_run = 0;
            m_state = ns;
        end
    endtask

    task automatic checkOutput();
        logic [79:0] exp_word;
        checkSignal("state_o",      80'(state_o),      80'(m_state));
        checkSignal("cal_req",      80'(cal_req),      80'(m_state == S_CAL));
        checkSignal("link_up",      80'(link_up),      80'(m_state == S_ACTIVE));
        checkSignal("link_err",     80'(link_err),     80'(m_state == S_FAIL));
        checkSignal("usr_tx_ready", 80'(usr_tx_ready), 80'(m_state == S_ACTIVE));
        checkSignal("aib_tx_data",  aib_tx_data,       m_tx);
        checkSignal("usr_rx_data",  usr_rx_data,       m_rxd);
        checkSignal("usr_rx_valid", 80'(usr_rx_valid), 80'(m_rxv));
        if (loopback && usr_rx_valid === 1'b1) begin
            rx_pulses++;
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL rx_payload observed=%h expected=<no word in flight>", usr_rx_data);
            end
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                checkSignal("rx_payload", usr_rx_data, exp_word);
            end
        end
    endtask

    task automatic applyStimulus();
        if (!rst && link_en && usr_tx_valid && (m_state == S_ACTIVE) && loopback)
            sb.push_back(usr_tx_data);
        @(posedge clk);
        modelStep();
        if (rst || !link_en) sb.delete();
        #1;
        checkOutput();
    endtask

    initial begin
        int n;
        rst = 1'b1; link_en = 1'b0; cal_done = 1'b0;
        usr_tx_valid = 1'b0; usr_tx_data = '0;
        loopback = 1'b1; rx_force = '0;
        m_state = S_IDLE; m_cyc = 0; m_run = 0;
        m_tx = IDLE_W; m_rxd = '0; m_rxv = 1'b0;

        // Reset state
        repeat (2) applyStimulus();

        // Bring-up in loopback, cal_done pulse after a few CAL cycles
        $display("[TB] bring-up in loopback");
        rst = 1'b0; link_en = 1'b1;
        repeat (4) applyStimulus();
        cal_done = 1'b1;
        applyStimulus();
        n = 0;
        while (state_o !== 3'd3 && n < 64) begin
            cal_done = 1'($urandom_range(0, 1));
            applyStimulus();
            n++;
        end
        cal_done = 1'b0;
        checkSignal("train_cycles_to_active", 80'(n), 80'(TRAIN_COUNT));

        // Five words with random gaps; each returns once through loopback
        $display("[TB] active traffic");
        rx_pulses = 0;
        for (int w = 1; w <= 5; w++) begin
            usr_tx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) applyStimulus();
            usr_tx_valid = 1'b1;
            usr_tx_data  = 80'(w);
            applyStimulus();
        end
        usr_tx_valid = 1'b0;
        repeat (4) applyStimulus();
        checkSignal("rx_valid_pulses", 80'(rx_pulses), 80'd5);

        // Random traffic, then drop link_en with a word offered
        repeat (40) begin
            usr_tx_valid = 1'($urandom_range(0, 1));
            usr_tx_data  = randWord() | 80'd1;
            applyStimulus();
        end
        link_en = 1'b0; usr_tx_valid = 1'b1;
        applyStimulus();
        usr_tx_valid = 1'b0;
        applyStimulus();

        // Calibration timeout: timer values 0..CAL_TIMEOUT each take one CAL cycle
        $display("[TB] calibration timeout");
        link_en = 1'b1;
        applyStimulus();
        n = 0;
        while (state_o !== 3'd4 && n < 1100) begin
            applyStimulus();
            n++;
        end
        checkSignal("cal_cycles_to_fail", 80'(n), 80'(CAL_TIMEOUT + 1));
        repeat (2) applyStimulus();
        link_en = 1'b0;
        applyStimulus();

        // cal_done on the timeout cycle wins, then alignment on the TRAIN timeout cycle wins
        $display("[TB] timeout ties");
        link_en = 1'b1;
        applyStimulus();
        repeat (CAL_TIMEOUT) applyStimulus();
        cal_done = 1'b1;
        applyStimulus();
        cal_done = 1'b0;
        checkSignal("tie_cal_done_wins", 80'(state_o), 80'(S_TRAIN));
        loopback = 1'b0;
        for (int k = 0; k <= CAL_TIMEOUT; k++) begin
            rx_force = (k >= CAL_TIMEOUT + 1 - TRAIN_COUNT) ? PAT : nonPatternWord();
            applyStimulus();
        end
        checkSignal("tie_align_wins", 80'(state_o), 80'(S_ACTIVE));
        link_en = 1'b0;
        applyStimulus();

        // Training timeout with only short runs of the pattern
        $display("[TB] training timeout");
        link_en = 1'b1; cal_done = 1'b1;
        repeat (2) applyStimulus();
        cal_done = 1'b0;
        n = 0;
        while (state_o !== 3'd4 && n < 1100) begin
            rx_force = (n % 5 == 0) ? PAT : nonPatternWord();
            applyStimulus();
            n++;
        end
        checkSignal("train_cycles_to_fail", 80'(n), 80'(CAL_TIMEOUT + 1));
        link_en = 1'b0;
        applyStimulus();

        // Ten matches, one mismatch, then a full run of the pattern
        $display("[TB] broken training run");
        link_en = 1'b1; cal_done = 1'b1;
        repeat (2) applyStimulus();
        cal_done = 1'b0;
        rx_force = PAT;
        repeat (10) applyStimulus();
        rx_force = nonPatternWord();
        applyStimulus();
        rx_force = PAT;
        n = 0;
        while (state_o !== 3'd3 && n < 40) begin
            applyStimulus();
            n++;
        end
        checkSignal("matches_after_break", 80'(n), 80'(TRAIN_COUNT));
        link_en = 1'b0;
        applyStimulus();

        // Reset in TRAIN with link_en held high, then CAL re-entered
        $display("[TB] reset during training");
        loopback = 1'b1; link_en = 1'b1; cal_done = 1'b1;
        repeat (2) applyStimulus();
        cal_done = 1'b0;
        repeat (5) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkSignal("rst_reenter_cal", 80'(state_o), 80'(S_CAL));
        repeat (2) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
